// File: rtl/mux2_1bit_if.sv
// Signal bundle for the 1-bit 2:1 select cell: two data bits, the select,
// the combinational/selected output and its flopped copy.
interface mux2_1bit_if;
  logic A;
  logic B;
  logic sel;
  logic OUT;
  logic OUT_Q;

  // There is no valid/ready handshake: the cell is always ready, so every
  // value on A/B/sel is consumed immediately and OUT_Q captures one per clock.
  modport master (output A, output B, output sel, input OUT, input OUT_Q);
  modport slave  (input A, input B, input sel, output OUT, output OUT_Q);
endinterface

// File: rtl/mux2_1bit.sv
// Leaf 1-bit select cell of the ALU datapath: OUT = sel ? B : A, plus a
// flopped copy OUT_Q; REG_OUT=1 makes OUT come from the flop instead.
module mux2_1bit #(
  parameter logic RESET_VAL = 1'b0,
  parameter bit   REG_OUT   = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  mux2_1bit_if.slave    bus
);

  logic out_d;
  logic out_q;

  // Conditional operator keeps the X-merge behaviour for an unknown select.
  assign out_d = bus.sel ? bus.B : bus.A;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= RESET_VAL;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.OUT_Q = out_q;

  generate
    if (REG_OUT) begin : g_reg_out
      assign bus.OUT = out_q;
    end else begin : g_comb_out
      assign bus.OUT = out_d;
    end
  endgenerate

endmodule

// File: tb/tb_mux2_1bit.sv
// Directed-vector bench for mux2_1bit: a combinational instance (REG_OUT=0)
// and a registered instance (REG_OUT=1, RESET_VAL=1) sharing clk and rst_n.
module tb_mux2_1bit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mux2_1bit_if bus0 ();
  mux2_1bit_if bus1 ();

  mux2_1bit #(.RESET_VAL(1'b0), .REG_OUT(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  mux2_1bit #(.RESET_VAL(1'b1), .REG_OUT(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus0.A = 1'b1; bus0.B = 1'b1; bus0.sel = 1'b0;
    bus1.A = 1'b0; bus1.B = 1'b0; bus1.sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus0.OUT_Q !== 1'b0) begin
      bad++; $display("FAIL reset_out_q0 got=%b exp=%b", bus0.OUT_Q, 1'b0);
    end
    total++;
    if (bus1.OUT_Q !== 1'b1) begin
      bad++; $display("FAIL reset_out_q1 got=%b exp=%b", bus1.OUT_Q, 1'b1);
    end
    total++;
    if (bus1.OUT !== 1'b1) begin
      bad++; $display("FAIL reset_reg_out got=%b exp=%b", bus1.OUT, 1'b1);
    end
    // combinational output ignores reset
    total++;
    if (bus0.OUT !== 1'b1) begin
      bad++; $display("FAIL reset_comb_out got=%b exp=%b", bus0.OUT, 1'b1);
    end
  endtask

  task automatic test_comb_sequence();
    bus0.A = 1'b0; bus0.B = 1'b1; bus0.sel = 1'b0;
    #1;
    total++;
    if (bus0.OUT !== 1'b0) begin
      bad++; $display("FAIL comb_a0 got=%b exp=%b", bus0.OUT, 1'b0);
    end
    #100;
    bus0.sel = 1'b1;
    #1;
    total++;
    if (bus0.OUT !== 1'b1) begin
      bad++; $display("FAIL comb_sel1 got=%b exp=%b", bus0.OUT, 1'b1);
    end
    bus0.B = 1'b0;
    #1;
    total++;
    if (bus0.OUT !== 1'b0) begin
      bad++; $display("FAIL comb_b0 got=%b exp=%b", bus0.OUT, 1'b0);
    end
    bus0.sel = 1'b0;
    #1;
    total++;
    if (bus0.OUT !== 1'b0) begin
      bad++; $display("FAIL comb_sel0 got=%b exp=%b", bus0.OUT, 1'b0);
    end
    bus0.A = 1'b1;
    #1;
    total++;
    if (bus0.OUT !== 1'b1) begin
      bad++; $display("FAIL comb_a1 got=%b exp=%b", bus0.OUT, 1'b1);
    end
  endtask

  task automatic test_exhaustive();
    // bit index = {A,B,sel}; value = sel ? B : A
    logic [7:0] exp_tbl;
    exp_tbl = 8'b1101_1000;
    for (int i = 0; i < 8; i++) begin
      bus0.A   = i[2];
      bus0.B   = i[1];
      bus0.sel = i[0];
      #1;
      total++;
      if (bus0.OUT !== exp_tbl[i]) begin
        bad++;
        $display("FAIL exhaustive_%0d got=%b exp=%b", i, bus0.OUT, exp_tbl[i]);
      end
    end
  endtask

  task automatic test_register_path();
    @(negedge clk);
    rst_n = 1'b1;
    bus0.A = 1'b1; bus0.B = 1'b0; bus0.sel = 1'b0;
    #1;
    total++;
    if (bus0.OUT_Q !== 1'b0) begin
      bad++; $display("FAIL reg_before_edge got=%b exp=%b", bus0.OUT_Q, 1'b0);
    end
    @(posedge clk); #1;
    total++;
    if (bus0.OUT_Q !== 1'b1) begin
      bad++; $display("FAIL reg_first_edge got=%b exp=%b", bus0.OUT_Q, 1'b1);
    end
    @(negedge clk);
    bus0.sel = 1'b1; bus0.B = 1'b0;
    #1;
    total++;
    if (bus0.OUT_Q !== 1'b1) begin
      bad++; $display("FAIL reg_hold got=%b exp=%b", bus0.OUT_Q, 1'b1);
    end
    @(posedge clk); #1;
    total++;
    if (bus0.OUT_Q !== 1'b0) begin
      bad++; $display("FAIL reg_second_edge got=%b exp=%b", bus0.OUT_Q, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    // per-cycle {A,B,sel}, flop result expected after that edge
    logic [2:0] vec [4];
    logic       exp [4];
    vec[0] = 3'b011; exp[0] = 1'b1;
    vec[1] = 3'b100; exp[1] = 1'b1;
    vec[2] = 3'b101; exp[2] = 1'b0;
    vec[3] = 3'b010; exp[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {bus0.A, bus0.B, bus0.sel} = vec[i];
      @(posedge clk); #1;
      total++;
      if (bus0.OUT_Q !== exp[i]) begin
        bad++; $display("FAIL b2b_%0d got=%b exp=%b", i, bus0.OUT_Q, exp[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus0.A = 1'b1; bus0.sel = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus0.OUT_Q !== 1'b1) begin
      bad++; $display("FAIL async_pre got=%b exp=%b", bus0.OUT_Q, 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus0.OUT_Q !== 1'b0) begin
      bad++; $display("FAIL async_drop got=%b exp=%b", bus0.OUT_Q, 1'b0);
    end
    bus0.A = 1'b0;
    #1;
    total++;
    if (bus0.OUT !== 1'b0) begin
      bad++; $display("FAIL async_comb_follow got=%b exp=%b", bus0.OUT, 1'b0);
    end
    bus0.A = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus0.OUT_Q !== 1'b0) begin
      bad++; $display("FAIL async_hold got=%b exp=%b", bus0.OUT_Q, 1'b0);
    end
  endtask

  task automatic test_reg_out();
    // rst_n is low on entry
    bus1.A = 1'b0; bus1.B = 1'b1; bus1.sel = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus1.OUT !== 1'b1) begin
      bad++; $display("FAIL regout_in_reset got=%b exp=%b", bus1.OUT, 1'b1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus1.OUT !== 1'b1) begin
      bad++; $display("FAIL regout_before_edge got=%b exp=%b", bus1.OUT, 1'b1);
    end
    @(posedge clk); #1;
    total++;
    if (bus1.OUT !== 1'b0) begin
      bad++; $display("FAIL regout_after_edge got=%b exp=%b", bus1.OUT, 1'b0);
    end
    @(negedge clk);
    bus1.sel = 1'b1;
    #1;
    total++;
    if (bus1.OUT !== 1'b0) begin
      bad++; $display("FAIL regout_latency got=%b exp=%b", bus1.OUT, 1'b0);
    end
    @(posedge clk); #1;
    total++;
    if (bus1.OUT !== 1'b1 || bus1.OUT_Q !== 1'b1) begin
      bad++; $display("FAIL regout_sel_b got=%b/%b exp=1/1", bus1.OUT, bus1.OUT_Q);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_comb_sequence();
    test_exhaustive();
    test_register_path();
    test_back_to_back();
    test_async_reset();
    test_reg_out();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
